// File: rtl/mem_stage_apb_bridge_if.sv
// APB master/slave bundle between the MEM-stage bridge and the peripheral mux.
// PSEL width follows the number of attached slaves.
interface mem_stage_apb_bridge_if #(
  parameter int NUM_SLAVES = 2
);
  logic [31:0]           PADDR;
  logic [NUM_SLAVES-1:0] PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [31:0]           PWDATA;
  logic [3:0]            PSTRB;
  logic [31:0]           PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/mem_stage_apb_bridge.sv
// MEM-stage access unit: RAM accesses pass straight through, peripheral-window
// accesses run one full APB transfer while the pipeline is stalled.
module mem_stage_apb_bridge #(
  parameter logic [31:0] PERIPH_BASE = 32'h4000_0000,
  parameter int          SLAVE_SPAN  = 12,
  parameter int          NUM_SLAVES  = 2,
  parameter int          TIMEOUT     = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [1:0]  MemStrobeM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [31:0] DMemRdata,
  output logic        DMemWE,
  output logic [31:0] ReadDataM,
  output logic        store_doneM,
  output logic [3:0]  peripheral_load,
  output logic        StallM,
  output logic        bus_err,
  mem_stage_apb_bridge_if.master apb
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  state_t                state;
  logic [CW-1:0]         cnt;
  logic [1:0]            idx_q;
  logic [31:0]           rdata_q;
  logic                  store_done_q;
  logic                  err_q;

  logic                  periph;
  logic [1:0]            idx;
  logic                  idx_ok;
  logic [NUM_SLAVES-1:0] sel_oh;
  logic [31:0]           wdata_fmt;
  logic [3:0]            strb_fmt;

  assign periph = (MemReadM | MemWriteM) &&
                  (ALUResultM[31:SLAVE_SPAN+2] == PERIPH_BASE[31:SLAVE_SPAN+2]);
  assign idx    = ALUResultM[SLAVE_SPAN+1:SLAVE_SPAN];
  assign idx_ok = int'(idx) < NUM_SLAVES;

  always_comb begin
    sel_oh = '0;
    for (int i = 0; i < NUM_SLAVES; i++)
      if (int'(idx) == i) sel_oh[i] = 1'b1;
  end

  // Sub-word stores are lane-replicated so the slave can take any byte lane.
  always_comb begin
    wdata_fmt = WriteDataM;
    strb_fmt  = 4'b1111;
    case (MemStrobeM)
      2'b00: begin
        wdata_fmt = {4{WriteDataM[7:0]}};
        strb_fmt  = 4'b0001 << ALUResultM[1:0];
      end
      2'b01: begin
        wdata_fmt = {2{WriteDataM[15:0]}};
        strb_fmt  = 4'b0011 << {ALUResultM[1], 1'b0};
      end
      default: begin
        wdata_fmt = WriteDataM;
        strb_fmt  = 4'b1111;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      idx_q        <= '0;
      rdata_q      <= '0;
      store_done_q <= 1'b0;
      err_q        <= 1'b0;
      apb.PADDR    <= '0;
      apb.PSEL     <= '0;
      apb.PENABLE  <= 1'b0;
      apb.PWRITE   <= 1'b0;
      apb.PWDATA   <= '0;
      apb.PSTRB    <= '0;
    end else begin
      case (state)
        IDLE: if (periph) begin
          idx_q      <= idx;
          cnt        <= '0;
          apb.PADDR  <= {ALUResultM[31:2], 2'b00};
          apb.PWRITE <= MemWriteM;
          apb.PWDATA <= wdata_fmt;
          apb.PSTRB  <= MemWriteM ? strb_fmt : 4'b0000;
          if (idx_ok) begin
            apb.PSEL <= sel_oh;
            state    <= SETUP;
          end else begin
            // No slave behind this window: fail without touching the bus.
            err_q        <= 1'b1;
            store_done_q <= 1'b0;
            rdata_q      <= '0;
            state        <= DONE;
          end
        end
        SETUP: begin
          apb.PENABLE <= 1'b1;
          state       <= ACCESS;
        end
        ACCESS: begin
          if (apb.PREADY) begin
            apb.PSEL     <= '0;
            apb.PENABLE  <= 1'b0;
            rdata_q      <= apb.PSLVERR ? 32'h0 : apb.PRDATA;
            err_q        <= apb.PSLVERR;
            store_done_q <= apb.PWRITE && !apb.PSLVERR;
            state        <= DONE;
          end else if (cnt == CW'(TIMEOUT)) begin
            apb.PSEL     <= '0;
            apb.PENABLE  <= 1'b0;
            rdata_q      <= '0;
            err_q        <= 1'b1;
            store_done_q <= 1'b0;
            state        <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          err_q        <= 1'b0;
          store_done_q <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // DONE releases the stall so the instruction retires on DONE's closing edge.
  assign StallM          = !rst && ((state == IDLE && periph) || state == SETUP || state == ACCESS);
  assign DMemWE          = (state == IDLE) && MemWriteM && !periph;
  assign ReadDataM       = (state == DONE) ? rdata_q : DMemRdata;
  assign peripheral_load = (state == DONE) ? ({2'b00, idx_q} + 4'd1) : 4'd0;
  assign store_doneM     = store_done_q;
  assign bus_err         = err_q;

endmodule

// File: tb/tb_mem_stage_apb_bridge.sv
// Randomized bench for mem_stage_apb_bridge: each access is expanded by a
// transaction-level model into its expected per-cycle output timeline.
module tb_mem_stage_apb_bridge;
  localparam int          NS   = 2;
  localparam int          SPAN = 12;
  localparam int          TO   = 4;
  localparam logic [31:0] BASE = 32'h4000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        MemReadM = 1'b0, MemWriteM = 1'b0;
  logic [1:0]  MemStrobeM = 2'b00;
  logic [31:0] ALUResultM = '0, WriteDataM = '0, DMemRdata = '0;
  logic        DMemWE, store_doneM, StallM, bus_err;
  logic [31:0] ReadDataM;
  logic [3:0]  peripheral_load;

  mem_stage_apb_bridge_if #(.NUM_SLAVES(NS)) apb();

  mem_stage_apb_bridge #(
    .PERIPH_BASE(BASE), .SLAVE_SPAN(SPAN), .NUM_SLAVES(NS), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .MemReadM(MemReadM), .MemWriteM(MemWriteM), .MemStrobeM(MemStrobeM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .DMemRdata(DMemRdata),
    .DMemWE(DMemWE), .ReadDataM(ReadDataM), .store_doneM(store_doneM),
    .peripheral_load(peripheral_load), .StallM(StallM), .bus_err(bus_err),
    .apb(apb)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          first, is_done;
    logic          chk_stall, stall, we, sd, err;
    logic [3:0]    pl;
    logic [NS-1:0] psel;
    logic          pen;
    logic          chk_rd;
    logic [31:0]   rd;
    logic          chk_apb, chk_wd, pwrite;
    logic [31:0]   paddr, pwdata;
    logic [3:0]    pstrb;
  } exp_t;

  exp_t exp_c;
  logic exp_valid = 1'b0;
  int   n_chk = 0, n_fail = 0;

  // Observations taken by the compare process for the directed literal checks.
  int          stall_cnt, acc_cnt;
  logic [31:0] seen_paddr, seen_pwdata, done_rd, last_rd;
  logic [3:0]  seen_pstrb, done_pl, last_pl;
  logic [NS-1:0] seen_psel, last_psel;
  logic        done_sd, done_err, last_stall, last_pen, last_sd, last_err;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, expv, $time);
    end
  endtask

  function automatic exp_t quiet(input logic [31:0] dm);
    exp_t e;
    e = '0;
    e.chk_stall = 1'b1;
    e.chk_rd    = 1'b1;
    e.rd        = dm;
    return e;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] wd);
    if (sz == 2'b00) return {24'h0, wd[7:0]} * 32'h0101_0101;
    if (sz == 2'b01) return {16'h0, wd[15:0]} * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [3:0] m_strb(input logic [1:0] sz, input logic [31:0] a);
    int bytes, off, m;
    bytes = 1 << ((sz == 2'b11) ? 2 : int'(sz));
    off   = int'(a[1:0]) & ~(bytes - 1);
    m     = ((1 << bytes) - 1) << off;
    return m[3:0];
  endfunction

  always @(negedge clk) begin
    if (exp_valid) begin
      if (exp_c.first) begin stall_cnt = 0; acc_cnt = 0; end
      if (exp_c.chk_stall) chk("StallM", 32'(StallM), 32'(exp_c.stall));
      chk("DMemWE", 32'(DMemWE), 32'(exp_c.we));
      chk("store_doneM", 32'(store_doneM), 32'(exp_c.sd));
      chk("bus_err", 32'(bus_err), 32'(exp_c.err));
      chk("peripheral_load", 32'(peripheral_load), 32'(exp_c.pl));
      chk("PSEL", 32'(apb.PSEL), 32'(exp_c.psel));
      chk("PENABLE", 32'(apb.PENABLE), 32'(exp_c.pen));
      if (exp_c.chk_rd) chk("ReadDataM", ReadDataM, exp_c.rd);
      if (exp_c.chk_apb) begin
        chk("PADDR", apb.PADDR, exp_c.paddr);
        chk("PWRITE", 32'(apb.PWRITE), 32'(exp_c.pwrite));
        chk("PSTRB", 32'(apb.PSTRB), 32'(exp_c.pstrb));
        if (exp_c.chk_wd) chk("PWDATA", apb.PWDATA, exp_c.pwdata);
      end
      if (StallM) stall_cnt++;
      if (apb.PENABLE) acc_cnt++;
      if (apb.PSEL != '0 && !apb.PENABLE) begin
        seen_psel = apb.PSEL; seen_paddr = apb.PADDR;
        seen_pstrb = apb.PSTRB; seen_pwdata = apb.PWDATA;
      end
      if (exp_c.is_done) begin
        done_rd = ReadDataM; done_pl = peripheral_load;
        done_sd = store_doneM; done_err = bus_err;
      end
      last_rd = ReadDataM; last_pl = peripheral_load; last_psel = apb.PSEL;
      last_stall = StallM; last_pen = apb.PENABLE; last_sd = store_doneM; last_err = bus_err;
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      MemReadM = 1'b0; MemWriteM = 1'b0;
      ALUResultM = $urandom; DMemRdata = $urandom; WriteDataM = $urandom;
      apb.PREADY = 1'($urandom); apb.PSLVERR = 1'($urandom); apb.PRDATA = $urandom;
      exp_c = quiet(DMemRdata);
      exp_valid = 1'b1;
    end
  endtask

  // w: slave wait states before PREADY (negative = never ready).
  // rst_at: cycle of the access at which reset is pulsed (0 = none).
  task automatic run_txn(input bit wr, input logic [1:0] sz, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] dm, input int w,
                         input bit slverr, input logic [31:0] prd, input int rst_at);
    exp_t e;
    bit p, bad, to, err;
    int idx, nacc, ncyc;
    logic [NS-1:0] oh;
    p    = (addr >> (SPAN + 2)) == (BASE >> (SPAN + 2));
    idx  = int'((addr >> SPAN) & 32'd3);
    bad  = idx >= NS;
    to   = (w < 0) || (w > TO);
    nacc = to ? TO + 1 : w + 1;
    err  = bad || to || slverr;
    oh   = '0;
    if (!bad) oh[idx] = 1'b1;
    ncyc = !p ? 1 : bad ? 2 : nacc + 3;
    for (int k = 0; k < ncyc; k++) begin
      @(posedge clk); #1;
      if (rst_at != 0 && k == rst_at) begin
        rst = 1'b1; MemReadM = 1'b0; MemWriteM = 1'b0; apb.PREADY = 1'b0;
        exp_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        e = quiet(DMemRdata);
        e.chk_apb = 1'b1; e.chk_wd = 1'b1;
        exp_c = e; exp_valid = 1'b1;
        break;
      end
      MemReadM = !wr; MemWriteM = wr; MemStrobeM = sz; DMemRdata = dm;
      ALUResultM = (k == 0 || !p) ? addr : $urandom;
      WriteDataM = (k == 0) ? wd : $urandom;
      apb.PREADY = 1'b0; apb.PSLVERR = 1'($urandom); apb.PRDATA = $urandom;
      e = quiet(dm);
      e.first = (k == 0);
      if (!p) begin
        e.we = wr;
      end else if (k == ncyc - 1) begin
        e.is_done = 1'b1;
        e.rd  = err ? 32'h0 : prd;
        e.pl  = 4'(idx + 1);
        e.sd  = wr && !err;
        e.err = err;
      end else begin
        e.stall = 1'b1; e.chk_rd = 1'b0;
        if (k >= 1) begin
          e.psel = oh; e.pen = (k >= 2);
          e.chk_apb = 1'b1; e.chk_wd = wr;
          e.paddr = {addr[31:2], 2'b00}; e.pwrite = wr;
          e.pwdata = m_wdata(sz, wd); e.pstrb = wr ? m_strb(sz, addr) : 4'b0000;
        end
        if (!to && k == nacc + 1) begin
          apb.PREADY = 1'b1; apb.PSLVERR = slverr; apb.PRDATA = prd;
        end
      end
      exp_c = e; exp_valid = 1'b1;
    end
    @(negedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout want finish");
    $fatal(1);
  end

  initial begin
    bit          r_wr, r_se;
    logic [1:0]  r_sz;
    logic [31:0] r_a;
    int          r_kind, r_w;
    exp_t        e;
    apb.PREADY = 1'b0; apb.PSLVERR = 1'b0; apb.PRDATA = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    e = quiet(DMemRdata); e.chk_apb = 1'b1; e.chk_wd = 1'b1;
    exp_c = e; exp_valid = 1'b1;
    idle(2);

    run_txn(0, 2'b10, 32'h0000_0010, 32'h0, 32'h1234_5678, 0, 0, 32'h0, 0);
    chk("tp_ram_rd", last_rd, 32'h1234_5678);
    chk("tp_ram_stall", 32'(stall_cnt), 32'd0);
    chk("tp_ram_pl", 32'(last_pl), 32'd0);
    idle(1);

    run_txn(1, 2'b00, 32'h4000_1003, 32'h0000_00A5, 32'h0, 0, 0, 32'h0, 0);
    chk("tp_uart_psel", 32'(seen_psel), 32'h2);
    chk("tp_uart_paddr", seen_paddr, 32'h4000_1000);
    chk("tp_uart_pstrb", 32'(seen_pstrb), 32'h8);
    chk("tp_uart_pwdata", seen_pwdata, 32'hA5A5_A5A5);
    chk("tp_uart_store_done", 32'(done_sd), 32'd1);
    chk("tp_uart_pl", 32'(done_pl), 32'd2);
    chk("tp_uart_stall", 32'(stall_cnt), 32'd3);

    run_txn(0, 2'b10, 32'h4000_0004, 32'h0, 32'h0, 2, 0, 32'hCAFE_0001, 0);
    chk("tp_wait_stall", 32'(stall_cnt), 32'd5);
    chk("tp_wait_rd", done_rd, 32'hCAFE_0001);
    chk("tp_wait_pl", 32'(done_pl), 32'd1);
    idle(1);

    run_txn(0, 2'b10, 32'h4000_0008, 32'h0, 32'h0, -1, 0, 32'h0, 0);
    chk("tp_to_access", 32'(acc_cnt), 32'd5);
    chk("tp_to_err", 32'(done_err), 32'd1);
    chk("tp_to_rd", done_rd, 32'h0);
    chk("tp_to_sd", 32'(done_sd), 32'd0);

    run_txn(1, 2'b10, 32'h4000_100C, 32'h1111_2222, 32'h0, 1, 1, 32'h0, 0);
    chk("tp_slverr_err", 32'(done_err), 32'd1);
    chk("tp_slverr_sd", 32'(done_sd), 32'd0);

    run_txn(0, 2'b10, 32'h4000_2000, 32'h0, 32'h0, 0, 0, 32'h0, 0);
    chk("tp_badidx_err", 32'(done_err), 32'd1);
    chk("tp_badidx_pl", 32'(done_pl), 32'd3);
    chk("tp_badidx_stall", 32'(stall_cnt), 32'd1);
    idle(1);

    run_txn(0, 2'b10, 32'h4000_0010, 32'h0, 32'h0, -1, 0, 32'h0, 3);
    chk("tp_rst_psel", 32'(last_psel), 32'd0);
    chk("tp_rst_pen", 32'(last_pen), 32'd0);
    chk("tp_rst_stall", 32'(last_stall), 32'd0);
    chk("tp_rst_pulses", {30'd0, last_sd, last_err}, 32'd0);
    idle(3);

    for (int t = 0; t < 120; t++) begin
      r_kind = int'($urandom_range(0, 9));
      r_wr   = 1'($urandom_range(0, 1));
      r_sz   = 2'($urandom_range(0, 2));
      r_w    = int'($urandom_range(0, 6));
      if ($urandom_range(0, 7) == 0) r_w = -1;
      r_se   = ($urandom_range(0, 4) == 0);
      if (r_kind < 4) begin
        r_a = $urandom;
        if ((r_a >> (SPAN + 2)) == (BASE >> (SPAN + 2))) r_a[31] = ~r_a[31];
      end else if (r_kind < 9) begin
        r_a = BASE | (32'($urandom_range(0, NS - 1)) << SPAN) | 32'($urandom_range(0, 4095));
      end else begin
        r_a = BASE | (32'($urandom_range(NS, 3)) << SPAN) | 32'($urandom_range(0, 4095));
      end
      run_txn(r_wr, r_sz, r_a, $urandom, $urandom, r_w, r_se, $urandom, 0);
      idle(int'($urandom_range(0, 2)));
    end

    idle(2);
    exp_valid = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_stage_apb_bridge.md
# mem_stage_apb_bridge

Memory-stage access unit of the pipelined RV32I core, sitting directly upstream of the MEM/WB pipeline register. It decodes each MEM-stage load/store address and either passes it through to data RAM or runs a complete APB master transfer to the peripheral window (GPIO, UART). While a peripheral transfer is in flight it stalls the pipeline. On completion it produces `ReadDataM`, `store_doneM` and `peripheral_load` for the MEM/WB register.

## Interface
- `PERIPH_BASE`, default 32'h4000_0000: base of the peripheral window.
- `SLAVE_SPAN`, default 12: log2 bytes per slave window (4 KB).
- `NUM_SLAVES`, default 2: number of APB slaves (index 0 = GPIO, 1 = UART); max 4.
- `TIMEOUT`, default 255: ACCESS cycles without `PREADY` before abort.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `MemReadM`  in  1  load in MEM.
- `MemWriteM`  in  1  store in MEM.
- `MemStrobeM`  in  2  size: 00 byte, 01 half, 10 word.
- `ALUResultM`  in  32  byte address.
- `WriteDataM`  in  32  store data, LSB-aligned.
- `DMemRdata`  in  32  data RAM read data (same cycle).
- `DMemWE`  out  1  data RAM write enable.
- `ReadDataM`  out  32  load data to MEM/WB.
- `store_doneM`  out  1  one-cycle pulse: peripheral store completed.
- `peripheral_load`  out  4  0 = RAM; slave index+1 for a peripheral access (UART = 2).
- `StallM`  out  1  freeze PC/IF/ID/EX/MEM and MEM/WB.
- `bus_err`  out  1  one-cycle pulse: `PSLVERR` or timeout.
- `PADDR`  out  32, `PSEL`  out  NUM_SLAVES, `PENABLE`  out  1, `PWRITE`  out  1, `PWDATA`  out  32, `PSTRB`  out  4: APB master outputs, all registered.
- `PRDATA`  in  32, `PREADY`  in  1, `PSLVERR`  in  1: APB responses, muxed from the selected slave externally.

## Operation
- Peripheral hit:
  - `periph = (MemReadM|MemWriteM) && ALUResultM[31:SLAVE_SPAN+2] == PERIPH_BASE[31:SLAVE_SPAN+2]`.
  - Slave index = `ALUResultM[SLAVE_SPAN+1:SLAVE_SPAN]`.
  - An index ≥ NUM_SLAVES is a hit that completes immediately in DONE with `bus_err`.
- RAM path, when `periph` = 0:
  - `DMemWE = MemWriteM`.
  - `ReadDataM = DMemRdata`.
  - `peripheral_load = 0`.
  - No stall.
- FSM states and transitions:
  - **IDLE**: on `periph`, latch the request and go to SETUP.
  - **SETUP**: drive `PSEL[idx]`=1, `PENABLE`=0. Next state is ACCESS.
  - **ACCESS**: drive `PENABLE`=1; the timeout counter increments each cycle.
    - `PREADY`=1: capture `PRDATA` and go to DONE.
    - Counter == TIMEOUT: go to DONE with error.
  - **DONE**: `PSEL`/`PENABLE`=0. Then IDLE.
- `StallM = (IDLE && periph) || SETUP || ACCESS`. It is deasserted in DONE, so the instruction advances on DONE's closing edge and is never re-issued.
- Outputs driven during DONE:
  - `ReadDataM` = captured `PRDATA`; forced to 0 on error.
  - `peripheral_load` = idx+1.
  - `store_doneM` = `PWRITE` && !error.
  - `bus_err` = `PSLVERR` or timeout.
  - `DMemWE` = 0.
- `DMemWE` is 0 whenever `periph` = 1.
- Address and data formatting:
  - `PADDR = {ALUResultM[31:2],2'b00}`.
  - `PWRITE = MemWriteM`.
  - `PWDATA`: byte replicated ×4, half replicated ×2, word as-is.
  - `PSTRB`: byte `4'b0001<<addr[1:0]`, half `4'b0011<<{addr[1],1'b0}`, word `4'b1111`.
  - `PSTRB` = 0 for reads.
- Reset:
  - Returns to IDLE and clears counter and latches.
  - All registered outputs go to 0: `PADDR`, `PSEL`, `PENABLE`, `PWRITE`, `PWDATA`, `PSTRB`, captured data.
  - `store_doneM`, `bus_err` = 0 after reset.
  - Reset mid-transfer drops `PSEL`/`PENABLE` at the next edge with no completion pulse.

## Timing
- RAM access: 0 added cycles.
- Peripheral access with a zero-wait slave:
  - Cycle 0: IDLE, stall.
  - Cycle 1: SETUP.
  - Cycle 2: ACCESS + `PREADY`.
  - Cycle 3: DONE, no stall.
  - Result: 3 stall cycles, 4 cycles in MEM.
- Each slave wait state adds 1 cycle.
- Timeout: DONE is reached after SETUP + (TIMEOUT+1) ACCESS cycles.
- `PREADY` and timeout on the same cycle: `PREADY` wins, no error.
- `PSLVERR` is sampled only together with `PREADY`.
- Back-to-back peripheral accesses: DONE → IDLE → SETUP. At least one cycle with `PSEL`=0 between transfers.
- Inputs are ignored outside IDLE; the request is latched at IDLE exit.

## Test plan
- RAM load at 0x0000_0010 with `DMemRdata`=0x1234_5678 → `ReadDataM`=0x1234_5678, `StallM`=0, `peripheral_load`=0.
- Byte store 0xA5 to 0x4000_1003 (UART):
  - SETUP: `PSEL`=2'b10, `PADDR`=0x4000_1000, `PSTRB`=4'b1000, `PWDATA`=0xA5A5_A5A5.
  - DONE: `store_doneM`=1, `peripheral_load`=2.
  - `StallM` high for exactly 3 cycles.
- Word load from 0x4000_0004 with 2 wait states and `PRDATA`=0xCAFE_0001 → 5 stall cycles, then `ReadDataM`=0xCAFE_0001, `peripheral_load`=1.
- Slave never asserts `PREADY` with TIMEOUT=4 → DONE after 5 ACCESS cycles, `bus_err`=1, `ReadDataM`=0, `store_doneM`=0.
- `PSLVERR`=1 with `PREADY` on a store → `bus_err`=1, `store_doneM`=0.
- `rst` asserted during ACCESS → next edge `PSEL`=0, `PENABLE`=0, `StallM`=0, FSM in IDLE, no pulses.
